// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package prefetch_pkg;

   localparam int DataWidth = 32;
   localparam int TagWidth  = DataWidth - 2;

   // Read-channel state: nothing outstanding, useful read outstanding,
   // or a read outstanding whose data must be dropped.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   // One buffered instruction: word address (byte offset stripped) plus data.
   typedef struct packed {
      logic [TagWidth-1:0]  tag;
      logic [DataWidth-1:0] data;
   } entry_t;

   // Byte address of the next sequential instruction word.
   function automatic logic [DataWidth-1:0] next_word(input logic [DataWidth-1:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/imem_prefetch_buffer_fetch_fifo.sv
// Small synchronous FIFO of prefetched instruction entries.
// Flush beats push and pop in the same cycle; head is readable combinationally.
module fetch_fifo
   import prefetch_pkg::*;
#(
   parameter int Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  entry_t                   push_entry_i,
   input  logic                     pop_i,
   output entry_t                   head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
   localparam logic [PtrW-1:0] PtrOne   = PtrW'(1'b1);
   localparam logic [CntW-1:0] CntOne   = CntW'(1'b1);

   entry_t          mem_r [Depth];
   logic [PtrW-1:0] rd_ptr_r;
   logic [PtrW-1:0] wr_ptr_r;
   logic [CntW-1:0] count_r;
   logic            do_push_s;
   logic            do_pop_s;

   assign head_o  = mem_r[rd_ptr_r];
   assign full_o  = (count_r == DepthCnt);
   assign empty_o = (count_r == '0);
   assign count_o = count_r;

   // Qualify pop with non-empty and push with space (a same-cycle pop frees a slot).
   always_comb begin
      do_pop_s  = pop_i && (count_r != '0);
      do_push_s = push_i && ((count_r != DepthCnt) || do_pop_s);
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush_i) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PtrOne;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PtrOne;
         end
         if (do_push_s && !do_pop_s) begin
            count_r <= count_r + CntOne;
         end else if (do_pop_s && !do_push_s) begin
            count_r <= count_r - CntOne;
         end
      end
   end

   // Entry storage; a flush cycle writes nothing.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            mem_r[i] <= '0;
         end
      end else if (!flush_i && do_push_s) begin
         mem_r[wr_ptr_r] <= push_entry_i;
      end
   end

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetch buffer between the core fetch port and memory.
// Reads ahead from consecutive word addresses into a FIFO; a fetch matching the
// FIFO head completes combinationally, any other fetch flushes and redirects.
// DWidth must equal prefetch_pkg::DataWidth since FIFO entries use entry_t.
module imem_prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int                DWidth    = DataWidth,
   parameter int                Depth     = 4,
   parameter logic [DWidth-1:0] IMemStart = 32'h0000_0000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              core_req_i,
   input  logic [DWidth-1:0] core_addr_i,
   output logic              core_ready_o,
   output logic [DWidth-1:0] core_rdata_o,
   output logic              mem_req_o,
   output logic [DWidth-1:0] mem_addr_o,
   input  logic              mem_ready_i,
   input  logic [DWidth-1:0] mem_rdata_i
);

   localparam int CntW = $clog2(Depth) + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   state_t            state_r;
   state_t            state_s;
   logic [DWidth-1:0] fetch_addr_r;
   logic [DWidth-1:0] fetch_addr_s;
   logic              mem_req_s;
   logic [DWidth-1:0] mem_addr_s;
   logic [DWidth-1:0] core_word_s;

   logic              hit_s;
   logic              bypass_s;
   logic              miss_s;
   logic              redirect_s;
   logic              push_s;
   logic              room_s;
   logic [CntW-1:0]   occ_next_s;

   entry_t            push_entry_s;
   entry_t            head_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CntW-1:0]   fifo_count_s;

   fetch_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (miss_s),
      .push_i       (push_s),
      .push_entry_i (push_entry_s),
      .pop_i        (hit_s),
      .head_o       (head_s),
      .full_o       (fifo_full_s),
      .empty_o      (fifo_empty_s),
      .count_o      (fifo_count_s)
   );

   // Classify the core request (hit / bypass / miss) and drive the core response.
   always_comb begin
      core_word_s  = core_addr_i & ~{{(DWidth-2){1'b0}}, 2'b11};
      hit_s        = 1'b0;
      bypass_s     = 1'b0;
      miss_s       = 1'b0;
      if (core_req_i) begin
         if (!fifo_empty_s && (head_s.tag == core_word_s[DWidth-1:2])) begin
            hit_s = 1'b1;
         end else if (fifo_empty_s && (state_r == FETCH) && mem_ready_i &&
                      (mem_addr_o == core_word_s)) begin
            bypass_s = 1'b1;
         end else begin
            miss_s = 1'b1;
         end
      end else begin
         hit_s    = 1'b0;
         bypass_s = 1'b0;
         miss_s   = 1'b0;
      end

      // In IDLE every miss restarts; otherwise only a miss away from the read target does.
      redirect_s = miss_s && ((state_r == IDLE) || (core_word_s != fetch_addr_r));

      // A completing useful read is buffered unless forwarded or flushed away.
      push_s            = (state_r == FETCH) && mem_ready_i && !miss_s && !bypass_s;
      push_entry_s.tag  = fetch_addr_r[DWidth-1:2];
      push_entry_s.data = mem_rdata_i;

      if (miss_s) begin
         occ_next_s = '0;
      end else begin
         occ_next_s = fifo_count_s + CntW'(push_s) - CntW'(hit_s);
      end
      room_s = (occ_next_s < DepthCnt);

      core_ready_o = hit_s | bypass_s;
      if (hit_s) begin
         core_rdata_o = head_s.data;
      end else if (bypass_s) begin
         core_rdata_o = mem_rdata_i;
      end else begin
         core_rdata_o = '0;
      end
   end

   // Read-channel next state; mem_req/mem_addr only move once a read completes.
   always_comb begin
      state_s      = state_r;
      fetch_addr_s = fetch_addr_r;
      mem_req_s    = mem_req_o;
      mem_addr_s   = mem_addr_o;
      case (state_r)
         IDLE: begin
            if (redirect_s) begin
               fetch_addr_s = core_word_s;
               state_s      = FETCH;
               mem_req_s    = 1'b1;
               mem_addr_s   = core_word_s;
            end else if (!fifo_full_s) begin
               state_s    = FETCH;
               mem_req_s  = 1'b1;
               mem_addr_s = fetch_addr_r;
            end else begin
               state_s   = IDLE;
               mem_req_s = 1'b0;
            end
         end
         FETCH: begin
            if (redirect_s) begin
               fetch_addr_s = core_word_s;
               if (mem_ready_i) begin
                  state_s   = IDLE;
                  mem_req_s = 1'b0;
               end else begin
                  state_s = DISCARD;
               end
            end else if (mem_ready_i) begin
               fetch_addr_s = next_word(fetch_addr_r);
               if (room_s) begin
                  state_s    = FETCH;
                  mem_addr_s = next_word(fetch_addr_r);
               end else begin
                  state_s   = IDLE;
                  mem_req_s = 1'b0;
               end
            end else begin
               state_s = FETCH;
            end
         end
         DISCARD: begin
            if (redirect_s) begin
               fetch_addr_s = core_word_s;
               if (mem_ready_i) begin
                  state_s   = IDLE;
                  mem_req_s = 1'b0;
               end else begin
                  state_s = DISCARD;
               end
            end else if (mem_ready_i) begin
               if (room_s) begin
                  state_s    = FETCH;
                  mem_req_s  = 1'b1;
                  mem_addr_s = fetch_addr_r;
               end else begin
                  state_s   = IDLE;
                  mem_req_s = 1'b0;
               end
            end else begin
               state_s = DISCARD;
            end
         end
         default: begin
            state_s   = IDLE;
            mem_req_s = 1'b0;
         end
      endcase
   end

   // Read-channel state and registered memory request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= IDLE;
         fetch_addr_r <= IMemStart;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= '0;
      end else begin
         state_r      <= state_s;
         fetch_addr_r <= fetch_addr_s;
         mem_req_o    <= mem_req_s;
         mem_addr_o   <= mem_addr_s;
      end
   end

endmodule
